wb_tlb_ctrl: RTL and testbench

Writeback-stage TLB maintenance controller for the LoongArch pipeline. It executes TLBRD, TLBWR, TLBFILL and INVTLB against the TLB read/write ports, with the entry count set by a parameter. TLBFILL uses a deterministic LFSR to pick the replacement entry, and INVTLB runs as a multi-cycle sweep over all entries, covering op codes 0–6. WB holds the instruction with a valid/ready handshake until the controller signals completion, then issues the refetch request.

---
 rtl/tlb_pkg.sv | 41 ++++
 rtl/tlb_inv_match.sv | 41 ++++
 rtl/wb_tlb_ctrl.sv | 174 +++++++++++++++++
 tb/tb_wb_tlb_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared encodings and helpers for the writeback-stage TLB maintenance controller.
package tlb_pkg;

  localparam logic [2:0] TLBOP_RD   = 3'd0;
  localparam logic [2:0] TLBOP_WR   = 3'd1;
  localparam logic [2:0] TLBOP_FILL = 3'd2;
  localparam logic [2:0] TLBOP_INV  = 3'd3;

  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  // TLBELO layout: {ppn[19:0], g, mat[1:0], plv[1:0], d, v}
  localparam int ELO_W      = 27;
  localparam int ELO_V      = 0;
  localparam int ELO_D      = 1;
  localparam int ELO_PLV_LO = 2;
  localparam int ELO_PLV_W  = 2;
  localparam int ELO_MAT_LO = 4;
  localparam int ELO_MAT_W  = 2;
  localparam int ELO_G      = 6;
  localparam int ELO_PPN_LO = 7;
  localparam int ELO_PPN_W  = 20;

  localparam logic [5:0] PS_4M = 6'd21;
  localparam logic [5:0] PS_4K = 6'd12;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One step of the x^16+x^14+x^13+x^11+1 Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  function automatic logic [ELO_W-1:0] elo_with_g(input logic [ELO_W-1:0] elo,
                                                  input logic g);
    logic [ELO_W-1:0] r;
    r        = elo;
    r[ELO_G] = g;
    return r;
  endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// INVTLB match rule for one TLB entry, evaluated on the read-port fields.
module tlb_inv_match
  import tlb_pkg::*;
(
  input  logic [4:0]  i_inv_op,
  input  logic [9:0]  i_inv_asid,
  input  logic [18:0] i_inv_vppn,
  input  logic        i_e,
  input  logic [18:0] i_vppn,
  input  logic [5:0]  i_ps,
  input  logic [9:0]  i_asid,
  input  logic        i_g,
  output logic        o_hit
);

  logic w_asid_eq;
  logic w_va_hit;
  logic w_rule;

  assign w_asid_eq = (i_asid == i_inv_asid);
  // A 4M page ignores the low 10 bits of vppn.
  assign w_va_hit  = (i_ps == PS_4M) ? (i_vppn[18:10] == i_inv_vppn[18:10])
                                     : (i_vppn == i_inv_vppn);

  always_comb begin
    // NOTE: default before the case so every path assigns w_rule; no latch.
    w_rule = 1'b0;
    case (i_inv_op)
      5'd0, 5'd1: w_rule = 1'b1;
      5'd2:       w_rule = i_g;
      5'd3:       w_rule = ~i_g;
      5'd4:       w_rule = ~i_g & w_asid_eq;
      5'd5:       w_rule = ~i_g & w_asid_eq & w_va_hit;
      5'd6:       w_rule = (i_g | w_asid_eq) & w_va_hit;
      default:    w_rule = 1'b0;
    endcase
  end

  assign o_hit = i_e & w_rule;

endmodule

// File: rtl/wb_tlb_ctrl.sv
// WB-stage TLB maintenance controller: TLBRD/TLBWR/TLBFILL and swept INVTLB.
module wb_tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int          TLBNUM    = 16,
  parameter int          IDX_W     = $clog2(TLBNUM),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [4:0]       req_inv_op,
  input  logic [9:0]       req_inv_asid,
  input  logic [18:0]      req_inv_vppn,
  input  logic [31:0]      req_pc,
  output logic             done,
  output logic             ine,
  output logic             refetch_valid,
  output logic [31:0]      refetch_pc,
  input  logic [IDX_W-1:0] csr_tlbidx_index,
  input  logic [5:0]       csr_tlbidx_ps,
  input  logic             csr_tlbidx_ne,
  input  logic [18:0]      csr_tlbehi_vppn,
  input  logic [9:0]       csr_asid,
  input  logic [ELO_W-1:0] csr_tlbelo0,
  input  logic [ELO_W-1:0] csr_tlbelo1,
  input  logic [5:0]       csr_estat_ecode,
  output logic [IDX_W-1:0] r_index,
  input  logic             r_e,
  input  logic [18:0]      r_vppn,
  input  logic [5:0]       r_ps,
  input  logic [9:0]       r_asid,
  input  logic             r_g,
  input  logic [ELO_W-1:0] r_elo0,
  input  logic [ELO_W-1:0] r_elo1,
  output logic             we,
  output logic [IDX_W-1:0] w_index,
  output logic             w_e,
  output logic [18:0]      w_vppn,
  output logic [5:0]       w_ps,
  output logic [9:0]       w_asid,
  output logic             w_g,
  output logic [ELO_W-1:0] w_elo0,
  output logic [ELO_W-1:0] w_elo1,
  output logic             tlbrd_we,
  output logic             tlbrd_valid,
  output logic [18:0]      tlbrd_vppn,
  output logic [5:0]       tlbrd_ps,
  output logic [9:0]       tlbrd_asid,
  output logic [ELO_W-1:0] tlbrd_elo0,
  output logic [ELO_W-1:0] tlbrd_elo1
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TLBNUM - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [15:0]      r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ine;
  logic [2:0]       r_req_op;
  logic [4:0]       r_req_inv_op;
  logic [9:0]       r_req_inv_asid;
  logic [18:0]      r_req_inv_vppn;
  logic [31:0]      r_req_pc;

  logic w_accept;
  logic w_inv_bad;
  logic w_hit;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_inv_bad = (req_inv_op > 5'd6);

  tlb_inv_match u_match (
    .i_inv_op   (r_req_inv_op),
    .i_inv_asid (r_req_inv_asid),
    .i_inv_vppn (r_req_inv_vppn),
    .i_e        (r_e),
    .i_vppn     (r_vppn),
    .i_ps       (r_ps),
    .i_asid     (r_asid),
    .i_g        (r_g),
    .o_hit      (w_hit)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_cnt   <= '0;
      r_ine   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_ine <= (req_op == TLBOP_INV) && w_inv_bad;
            if ((req_op == TLBOP_INV) && !w_inv_bad) r_state <= S_SWEEP;
            else                                     r_state <= S_DONE;
            if (req_op == TLBOP_FILL) r_lfsr <= lfsr_next(r_lfsr);
          end
        end
        S_SWEEP: begin
          if (r_cnt == CNT_LAST) r_state <= S_DONE;
          else                   r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; they are only read behind the FSM.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req_op       <= req_op;
      r_req_inv_op   <= req_inv_op;
      r_req_inv_asid <= req_inv_asid;
      r_req_inv_vppn <= req_inv_vppn;
      r_req_pc       <= req_pc;
      if (req_op == TLBOP_RD) begin
        tlbrd_valid <= r_e;
        tlbrd_vppn  <= r_vppn;
        tlbrd_ps    <= r_ps;
        tlbrd_asid  <= r_asid;
        tlbrd_elo0  <= elo_with_g(r_elo0, r_g);
        tlbrd_elo1  <= elo_with_g(r_elo1, r_g);
      end
    end
  end

  // The TLB ports default to the CSR view; the sweep takes them over.
  always_comb begin
    r_index = csr_tlbidx_index;
    we      = 1'b0;
    w_index = csr_tlbidx_index;
    w_e     = (csr_estat_ecode == ECODE_TLBR) ? 1'b1 : ~csr_tlbidx_ne;
    w_vppn  = csr_tlbehi_vppn;
    w_ps    = csr_tlbidx_ps;
    w_asid  = csr_asid;
    w_g     = csr_tlbelo0[ELO_G] & csr_tlbelo1[ELO_G];
    w_elo0  = csr_tlbelo0;
    w_elo1  = csr_tlbelo1;
    if (r_state == S_SWEEP) begin
      r_index = r_cnt[IDX_W-1:0];
      we      = w_hit;
      w_index = r_cnt[IDX_W-1:0];
      w_e     = 1'b0;
      w_vppn  = r_vppn;
      w_ps    = r_ps;
      w_asid  = r_asid;
      w_g     = r_g;
      w_elo0  = r_elo0;
      w_elo1  = r_elo1;
    end else if (w_accept && ((req_op == TLBOP_WR) || (req_op == TLBOP_FILL))) begin
      we = 1'b1;
      if (req_op == TLBOP_FILL) w_index = r_lfsr[IDX_W-1:0];
    end
  end

  assign done          = (r_state == S_DONE);
  assign ine           = done & r_ine;
  assign refetch_valid = done & ~r_ine;
  assign refetch_pc    = r_req_pc + 32'd4;
  assign tlbrd_we      = done & (r_req_op == TLBOP_RD);

endmodule

// File: tb/tb_wb_tlb_ctrl.sv
// Directed bench for wb_tlb_ctrl with a 16-entry TLB array model behind the ports.
module tb_wb_tlb_ctrl;
  import tlb_pkg::*;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;

  logic        clk, resetn;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_inv_op;
  logic [9:0]  req_inv_asid;
  logic [18:0] req_inv_vppn;
  logic [31:0] req_pc;
  logic        done, ine, refetch_valid;
  logic [31:0] refetch_pc;
  logic [IDX_W-1:0] csr_tlbidx_index;
  logic [5:0]  csr_tlbidx_ps;
  logic        csr_tlbidx_ne;
  logic [18:0] csr_tlbehi_vppn;
  logic [9:0]  csr_asid;
  logic [26:0] csr_tlbelo0, csr_tlbelo1;
  logic [5:0]  csr_estat_ecode;
  logic [IDX_W-1:0] r_index;
  logic        r_e, r_g;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [26:0] r_elo0, r_elo1;
  logic        we, w_e, w_g;
  logic [IDX_W-1:0] w_index;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [26:0] w_elo0, w_elo1;
  logic        tlbrd_we, tlbrd_valid;
  logic [18:0] tlbrd_vppn;
  logic [5:0]  tlbrd_ps;
  logic [9:0]  tlbrd_asid;
  logic [26:0] tlbrd_elo0, tlbrd_elo1;

  wb_tlb_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vppn(req_inv_vppn),
    .req_pc(req_pc), .done(done), .ine(ine),
    .refetch_valid(refetch_valid), .refetch_pc(refetch_pc),
    .csr_tlbidx_index(csr_tlbidx_index), .csr_tlbidx_ps(csr_tlbidx_ps),
    .csr_tlbidx_ne(csr_tlbidx_ne), .csr_tlbehi_vppn(csr_tlbehi_vppn),
    .csr_asid(csr_asid), .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1),
    .csr_estat_ecode(csr_estat_ecode),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
    .r_g(r_g), .r_elo0(r_elo0), .r_elo1(r_elo1),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_g(w_g), .w_elo0(w_elo0), .w_elo1(w_elo1),
    .tlbrd_we(tlbrd_we), .tlbrd_valid(tlbrd_valid), .tlbrd_vppn(tlbrd_vppn),
    .tlbrd_ps(tlbrd_ps), .tlbrd_asid(tlbrd_asid),
    .tlbrd_elo0(tlbrd_elo0), .tlbrd_elo1(tlbrd_elo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TLB array model: DUT writes win, the bench preload port fills entries.
  logic        m_e    [TLBNUM];
  logic [18:0] m_vppn [TLBNUM];
  logic [5:0]  m_ps   [TLBNUM];
  logic [9:0]  m_asid [TLBNUM];
  logic        m_g    [TLBNUM];
  logic [26:0] m_elo0 [TLBNUM];
  logic [26:0] m_elo1 [TLBNUM];

  logic        pl_we, pl_e, pl_g;
  logic [IDX_W-1:0] pl_idx;
  logic [18:0] pl_vppn;
  logic [5:0]  pl_ps;
  logic [9:0]  pl_asid;
  logic [26:0] pl_elo0, pl_elo1;

  int          wr_cnt = 0;
  logic [IDX_W-1:0] last_widx;
  logic        last_we_e;

  assign r_e    = m_e[r_index];
  assign r_vppn = m_vppn[r_index];
  assign r_ps   = m_ps[r_index];
  assign r_asid = m_asid[r_index];
  assign r_g    = m_g[r_index];
  assign r_elo0 = m_elo0[r_index];
  assign r_elo1 = m_elo1[r_index];

  always @(posedge clk) begin
    if (we) begin
      m_e[w_index]    <= w_e;
      m_vppn[w_index] <= w_vppn;
      m_ps[w_index]   <= w_ps;
      m_asid[w_index] <= w_asid;
      m_g[w_index]    <= w_g;
      m_elo0[w_index] <= w_elo0;
      m_elo1[w_index] <= w_elo1;
      wr_cnt          <= wr_cnt + 1;
      last_widx       <= w_index;
      last_we_e       <= w_e;
    end else if (pl_we) begin
      m_e[pl_idx]    <= pl_e;
      m_vppn[pl_idx] <= pl_vppn;
      m_ps[pl_idx]   <= pl_ps;
      m_asid[pl_idx] <= pl_asid;
      m_g[pl_idx]    <= pl_g;
      m_elo0[pl_idx] <= pl_elo0;
      m_elo1[pl_idx] <= pl_elo1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic e, input logic [18:0] vppn,
                         input logic [5:0] ps, input logic [9:0] asid, input logic g,
                         input logic [26:0] elo0, input logic [26:0] elo1);
    pl_idx = idx[IDX_W-1:0]; pl_e = e; pl_vppn = vppn; pl_ps = ps;
    pl_asid = asid; pl_g = g; pl_elo0 = elo0; pl_elo1 = elo1;
    pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic clear_tlb();
    for (int i = 0; i < TLBNUM; i++) preload(i, 1'b0, 19'h0, PS_4K, 10'h0, 1'b0, 27'h0, 27'h0);
  endtask

  // Called at a negedge while idle; the request is accepted on the next posedge.
  task automatic issue(input logic [2:0] op, input logic [4:0] iop,
                       input logic [9:0] asid, input logic [18:0] vppn, input logic [31:0] pc);
    req_op = op; req_inv_op = iop; req_inv_asid = asid; req_inv_vppn = vppn;
    req_pc = pc; req_valid = 1'b1;
    #1;
  endtask

  task automatic wait_done(output int lat);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [IDX_W-1:0] fill_exp [3];
  int lat;
  int wr0;

  initial begin
    fill_exp[0] = 4'h1; fill_exp[1] = 4'h0; fill_exp[2] = 4'h8;
    resetn = 1'b0; req_valid = 1'b0; req_op = TLBOP_RD; req_inv_op = 5'd0;
    req_inv_asid = 10'h0; req_inv_vppn = 19'h0; req_pc = 32'h0;
    csr_tlbidx_index = 4'h0; csr_tlbidx_ps = PS_4K; csr_tlbidx_ne = 1'b0;
    csr_tlbehi_vppn = 19'h0ABCD; csr_asid = 10'h011;
    csr_tlbelo0 = 27'h0000041; csr_tlbelo1 = 27'h0000003; csr_estat_ecode = 6'h00;
    pl_we = 1'b0; pl_idx = '0; pl_e = 1'b0; pl_vppn = '0; pl_ps = '0;
    pl_asid = '0; pl_g = 1'b0; pl_elo0 = '0; pl_elo1 = '0;

    @(negedge clk);
    clear_tlb();
    check("rst_ready", req_ready, 1'b1);
    check("rst_pulses", {done, ine, refetch_valid, we, tlbrd_we}, 5'b0);
    resetn = 1'b1;
    @(negedge clk);

    // TLBFILL x3: index from successive LFSR states ACE1, E270, 7138
    for (int k = 0; k < 3; k++) begin
      issue(TLBOP_FILL, 5'd0, 10'h0, 19'h0, 32'h1C00_0000 + 32'(k * 16));
      check("fill_we", we, 1'b1);
      check("fill_idx", w_index, fill_exp[k]);
      check("fill_we_e", w_e, 1'b1);
      check("fill_wg", w_g, 1'b0);
      wait_done(lat);
      check("fill_lat", lat, 1);
      check("fill_refetch", {refetch_valid, refetch_pc}, {1'b1, 32'h1C00_0004 + 32'(k * 16)});
      @(negedge clk);
    end

    // TLBWR: ne=1 outside refill gives e=0, refill context forces e=1
    csr_tlbidx_index = 4'd5; csr_tlbidx_ne = 1'b1;
    csr_tlbelo0 = 27'h0000041; csr_tlbelo1 = 27'h0000043;
    issue(TLBOP_WR, 5'd0, 10'h0, 19'h0, 32'h1C00_0200);
    check("wr_we", we, 1'b1);
    check("wr_idx", w_index, 4'd5);
    check("wr_e_ne", w_e, 1'b0);
    check("wr_g", w_g, 1'b1);
    wait_done(lat);
    check("wr_lat", lat, 1);
    @(negedge clk);
    csr_estat_ecode = 6'h3f;
    issue(TLBOP_WR, 5'd0, 10'h0, 19'h0, 32'h1C00_0204);
    check("wr_e_refill", w_e, 1'b1);
    wait_done(lat);
    @(negedge clk);
    csr_estat_ecode = 6'h00; csr_tlbidx_ne = 1'b0;

    // TLBRD of entry 7; elo.g is replaced by the entry's g bit (0)
    preload(7, 1'b1, 19'h12345, PS_4K, 10'd3, 1'b0, 27'h0ABCD5F, 27'h1111103);
    csr_tlbidx_index = 4'd7;
    issue(TLBOP_RD, 5'd0, 10'h0, 19'h0, 32'h1C00_0300);
    check("rd_index", r_index, 4'd7);
    check("rd_no_we", we, 1'b0);
    wait_done(lat);
    check("rd_lat", lat, 1);
    check("rd_tlbrd_we", tlbrd_we, 1'b1);
    check("rd_valid", tlbrd_valid, 1'b1);
    check("rd_vppn", tlbrd_vppn, 19'h12345);
    check("rd_ps", tlbrd_ps, 6'd12);
    check("rd_asid", tlbrd_asid, 10'd3);
    check("rd_elo0", tlbrd_elo0, 27'h0ABCD1F);
    check("rd_elo1", tlbrd_elo1, 27'h1111103);
    @(negedge clk);
    check("rd_tlbrd_we_off", tlbrd_we, 1'b0);

    // INVTLB op 4 asid 3: only the non-global asid-3 entry goes
    clear_tlb();
    preload(2, 1'b1, 19'h00100, PS_4K, 10'd3, 1'b0, 27'h0, 27'h0);
    preload(4, 1'b1, 19'h00200, PS_4K, 10'd3, 1'b1, 27'h0, 27'h0);
    preload(9, 1'b1, 19'h00300, PS_4K, 10'd8, 1'b0, 27'h0, 27'h0);
    wr0 = wr_cnt;
    issue(TLBOP_INV, 5'd4, 10'd3, 19'h0, 32'h1C00_0400);
    check("inv4_no_we_accept", we, 1'b0);
    wait_done(lat);
    check("inv4_lat", lat, 17);
    check("inv4_writes", wr_cnt - wr0, 1);
    check("inv4_widx", last_widx, 4'd2);
    check("inv4_we_e", last_we_e, 1'b0);
    check("inv4_entries", {m_e[2], m_e[4], m_e[9]}, 3'b011);
    check("inv4_done", {done, ine, refetch_valid}, 3'b101);
    check("inv4_pc", refetch_pc, 32'h1C00_0404);
    @(negedge clk);
    check("inv4_ready", req_ready, 1'b1);

    // INVTLB op 5: vppn differs only in bits [9:0]
    preload(3, 1'b1, 19'h2A5FF, PS_4M, 10'd5, 1'b0, 27'h0, 27'h0);
    wr0 = wr_cnt;
    issue(TLBOP_INV, 5'd5, 10'd5, 19'h2A400, 32'h1C00_0500);
    wait_done(lat);
    check("inv5_4m_lat", lat, 17);
    check("inv5_4m_e", m_e[3], 1'b0);
    check("inv5_4m_writes", wr_cnt - wr0, 1);
    @(negedge clk);
    preload(3, 1'b1, 19'h2A5FF, PS_4K, 10'd5, 1'b0, 27'h0, 27'h0);
    wr0 = wr_cnt;
    issue(TLBOP_INV, 5'd5, 10'd5, 19'h2A400, 32'h1C00_0504);
    wait_done(lat);
    check("inv5_4k_e", m_e[3], 1'b1);
    check("inv5_4k_writes", wr_cnt - wr0, 0);
    @(negedge clk);

    // INVTLB op 7: ine with done, no writes
    wr0 = wr_cnt;
    issue(TLBOP_INV, 5'd7, 10'd0, 19'h0, 32'h1C00_0600);
    check("inv7_no_we", we, 1'b0);
    wait_done(lat);
    check("inv7_lat", lat, 1);
    check("inv7_pulses", {done, ine, refetch_valid}, 3'b110);
    check("inv7_writes", wr_cnt - wr0, 0);
    @(negedge clk);

    // Reset mid-sweep; a FILL held on req_valid while busy must be ignored
    clear_tlb();
    wr0 = wr_cnt;
    issue(TLBOP_INV, 5'd0, 10'd0, 19'h0, 32'h1C00_0700);
    @(negedge clk);
    req_op = TLBOP_FILL;
    check("sweep_not_ready", req_ready, 1'b0);
    for (int c = 0; c < 4; c++) @(negedge clk);
    check("sweep_busy_writes", wr_cnt - wr0, 0);
    resetn = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rst_sweep_ready", req_ready, 1'b1);
    check("rst_sweep_done", done, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    issue(TLBOP_FILL, 5'd0, 10'h0, 19'h0, 32'h1C00_0800);
    check("rst_lfsr_idx", w_index, 4'h1);
    wait_done(lat);
    check("rst_fill_lat", lat, 1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
